demux_1x4_stream: RTL and testbench
===================================

// Module: demux_1x4_stream
// PURPOSE
//   1-to-4 demultiplexer for a valid/ready stream: the opposite end of our 4:1 mux path.
//   Routes each input beat to one of four output channels by a 2-bit select.
//   Each channel has a registered one-entry holding stage and a wrapping delivered-beat counter.
//   Sits between a single producer and four independent consumers that can stall.
// PARAMETERS
//   WIDTH    8   data bits per beat
//   CNT_W    8   width of each per-channel delivered-beat counter
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          producer has a beat on in_data/in_sel
//   in_ready   out  1          demux accepts the beat this cycle
//   in_data    in   WIDTH      beat payload
//   in_sel     in   2          destination channel 0..3
//   out_valid  out  4          bit k: channel k holds a beat
//   out_ready  in   4          bit k: consumer k takes the beat this cycle
//   out_data   out  4*WIDTH    channel k payload at [k*WIDTH +: WIDTH]
//   out_cnt    out  4*CNT_W    channel k delivered count at [k*CNT_W +: CNT_W]
// BEHAVIOUR
//   Reset (rst_n low, async)
//     - out_valid=0, out_data=0, out_cnt=0.
//     - in_ready is combinational and therefore reads 1 while in reset.
//     - Beats held at reset assertion are discarded. Nothing is replayed after release.
//   Input handshake
//     - in_ready = ~out_valid[in_sel] | out_ready[in_sel]. Combinational from in_sel and out_ready only.
//     - in_ready does not depend on in_valid.
//     - Accept when in_valid & in_ready at a rising edge of clk.
//   Channel k state
//     - Two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
//     - EMPTY -> FULL: on an accept with in_sel==k. Load in_data into the channel register.
//     - FULL -> EMPTY: on out_ready[k] with no accept targeting k.
//     - FULL -> FULL (reload): on out_ready[k] and an accept targeting k in the same cycle.
//       The new beat replaces the old with no bubble, so throughput is 1 beat/clk per channel.
//     - FULL with out_ready[k]=0: out_data[k] and out_valid[k] are held stable. in_ready=0 when in_sel==k.
//   Latency
//     - Accept at edge N gives out_valid[k]=1 with the beat after edge N. That is 1-cycle latency.
//   Channel independence
//     - A stalled channel never blocks beats addressed to other channels.
//     - At most one channel loads per cycle. Any number of channels may drain in the same cycle.
//   Invalid input
//     - in_sel and in_data are ignored when in_valid=0.
//     - Channel registers never change except on accept or drain.
//   Counters
//     - out_cnt[k] += 1 on each out_valid[k] & out_ready[k].
//     - Unsigned, wraps 2^CNT_W-1 -> 0 with no flag.
//   out_ready
//     - out_ready[k] while out_valid[k]=0 has no effect and does not change out_cnt.
// TESTING
//   T1 reset
//     - Assert rst_n=0 mid-run with ch2 FULL (0xA5) and ch2 cnt=3.
//     - Required: out_valid=0000, all cnt=0, in_ready=1 immediately, without waiting for a clock edge.
//   T2 routing
//     - Send 0x00,0x11,0x22,0x33 with sel 0,1,2,3 and out_ready=1111.
//     - Required: each beat appears on its own channel 1 cycle later.
//     - Required: cnt=1 on every channel, no beat appears on any other channel.
//   T3 stall
//     - out_ready[1]=0; send 0x5A sel=1, then 0x6B sel=1.
//     - Required: ch1 holds 0x5A, in_ready=0 for the second beat.
//     - Required: raise out_ready[1] -> 0x5A delivered, 0x6B loads the same edge, cnt1=1, then 2.
//   T4 independence
//     - ch3 stalled FULL; send 0x77 sel=0.
//     - Required: in_ready=1, ch0 gets 0x77 next cycle, ch3 data unchanged.
//   T5 back-to-back
//     - 16 consecutive beats sel=2, out_ready[2]=1.
//     - Required: no bubbles, in_ready stays 1, data order preserved, cnt2=16.
//   T6 wrap
//     - Deliver 257 beats on ch0 with CNT_W=8.
//     - Required: cnt0 reads 255 after beat 255, 0 after beat 256, 1 after beat 257.

Source files
------------

// File: rtl/demux_1x4_stream_if.sv
// demux_1x4_stream_if: producer-side and four consumer-side valid/ready signals of the 1-to-4 demux
interface demux_1x4_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [4*CNT_W-1:0] out_cnt;
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );
endinterface

// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream: routes a valid/ready stream to one of four channels, each with a one-entry holding stage and a delivered-beat counter
module demux_1x4_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  demux_1x4_stream_if.slave s
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           st     [4];
  logic [WIDTH-1:0] data_q [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [3:0]       load;
  assign s.in_ready = ~s.out_valid[s.in_sel] | s.out_ready[s.in_sel];
  assign load = (s.in_valid & s.in_ready) ? 4'b0001 << s.in_sel : 4'b0000;
  for (genvar k = 0; k < 4; k++) begin : g_ch
    // a load wins over a drain, so a draining channel reloads without a bubble
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st[k]     <= EMPTY;
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end else begin
        if (load[k]) begin
          st[k]     <= FULL;
          data_q[k] <= s.in_data;
        end else if (s.out_ready[k])
          st[k] <= EMPTY;
        if (s.out_valid[k] & s.out_ready[k])
          cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    assign s.out_valid[k]                 = st[k] == FULL;
    assign s.out_data[k*WIDTH +: WIDTH]   = data_q[k];
    assign s.out_cnt[k*CNT_W +: CNT_W]    = cnt_q[k];
  end
endmodule

// File: tb/tb_demux_1x4_stream.sv
// tb_demux_1x4_stream: scenario tasks plus a per-channel scoreboard for the 1-to-4 stream demux
module tb_demux_1x4_stream;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb [4][$];
  logic [7:0] exp_cnt [4];
  demux_1x4_stream_if #(.WIDTH(8), .CNT_W(8)) dif ();
  demux_1x4_stream #(.WIDTH(8), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .s(dif.slave));
  always #5 clk = ~clk;
  function automatic logic [7:0] dat(input int k);
    return dif.out_data[k*8 +: 8];
  endfunction
  function automatic logic [7:0] cnt(input int k);
    return dif.out_cnt[k*8 +: 8];
  endfunction
  // scoreboard: inputs are stable at negedge, so this sees exactly what the next posedge will do
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        sb[k].delete();
        exp_cnt[k] = 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (cnt(k) !== exp_cnt[k]) begin
          n_err++;
          $display("FAIL sb_cnt ch%0d: got %0d expected %0d", k, cnt(k), exp_cnt[k]);
        end
        n_cmp++;
        if (dif.out_valid[k]) begin
          if (sb[k].size() == 0 || dat(k) !== sb[k][0]) begin
            n_err++;
            $display("FAIL sb_data ch%0d: got %h expected %h (queued %0d)", k, dat(k),
                     sb[k].size() ? sb[k][0] : 8'hxx, sb[k].size());
          end
          if (dif.out_ready[k]) begin
            if (sb[k].size() != 0) void'(sb[k].pop_front());
            exp_cnt[k] = exp_cnt[k] + 8'd1;
          end
        end else if (sb[k].size() != 0) begin
          n_err++;
          $display("FAIL sb_lost ch%0d: got out_valid 0 expected beat %h", k, sb[k][0]);
        end
      end
      if (dif.in_valid && dif.in_ready) sb[dif.in_sel].push_back(dif.in_data);
    end
  end
  task automatic send(input logic [7:0] d, input logic [1:0] sel);
    bit ok = 0;
    dif.in_valid = 1'b1;
    dif.in_data  = d;
    dif.in_sel   = sel;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = dif.in_ready;
    end
    if (!ok) begin
      n_err++;
      $display("FAIL send_timeout: got in_ready 0 for 50 cycles expected 1 (sel %0d)", sel);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b1;
    dif.in_valid = 1'b0; dif.in_data = '0; dif.in_sel = '0; dif.out_ready = '0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dif.out_valid !== 4'b0000 || dif.out_cnt !== '0 || dif.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL por: got valid %b cnt %h ready %b expected 0000 0 1", dif.out_valid, dif.out_cnt, dif.in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dif.out_ready = 4'b0100;
    for (int i = 0; i < 3; i++) send(8'(i), 2'd2);
    send(8'hA5, 2'd2);
    dif.out_ready = 4'b0000;
    dif.in_valid  = 1'b0;
    n_cmp++;
    if (dif.out_valid !== 4'b0100 || dat(2) !== 8'hA5 || cnt(2) !== 8'd3) begin
      n_err++;
      $display("FAIL pre_reset: got valid %b data %h cnt %0d expected 0100 a5 3", dif.out_valid, dat(2), cnt(2));
    end
    dif.in_sel = 2'd2;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dif.out_valid !== 4'b0000 || dif.out_cnt !== '0 || dif.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got valid %b cnt %h ready %b expected 0000 0 1", dif.out_valid, dif.out_cnt, dif.in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_routing;
    logic [7:0] d;
    dif.out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      d = 8'(k * 8'h11);
      send(d, 2'(k));
      n_cmp++;
      if (dif.out_valid !== 4'(1 << k) || dat(k) !== d) begin
        n_err++;
        $display("FAIL route ch%0d: got valid %b data %h expected %b %h", k, dif.out_valid, dat(k), 4'(1 << k), d);
      end
    end
    dif.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (dif.out_cnt !== 32'h01010101 || dif.out_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL route_cnt: got cnt %h valid %b expected 01010101 0000", dif.out_cnt, dif.out_valid);
    end
  endtask
  task automatic test_stall;
    logic [7:0] c0;
    dif.out_ready = 4'b1101;
    send(8'h5A, 2'd1);
    c0 = cnt(1);
    dif.in_data = 8'h6B;
    #1;
    n_cmp++;
    if (dif.in_ready !== 1'b0 || dat(1) !== 8'h5A) begin
      n_err++;
      $display("FAIL stall_ready: got ready %b data %h expected 0 5a", dif.in_ready, dat(1));
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dif.out_valid[1] !== 1'b1 || dat(1) !== 8'h5A || cnt(1) !== c0) begin
      n_err++;
      $display("FAIL stall_hold: got valid %b data %h cnt %0d expected 1 5a %0d", dif.out_valid[1], dat(1), cnt(1), c0);
    end
    dif.out_ready = 4'b1111;
    #1;
    n_cmp++;
    if (dif.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: got in_ready %b expected 1", dif.in_ready);
    end
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    n_cmp++;
    if (dif.out_valid[1] !== 1'b1 || dat(1) !== 8'h6B || cnt(1) !== c0 + 8'd1) begin
      n_err++;
      $display("FAIL stall_reload: got valid %b data %h cnt %0d expected 1 6b %0d", dif.out_valid[1], dat(1), cnt(1), c0 + 8'd1);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dif.out_valid[1] !== 1'b0 || cnt(1) !== c0 + 8'd2) begin
      n_err++;
      $display("FAIL stall_drain: got valid %b cnt %0d expected 0 %0d", dif.out_valid[1], cnt(1), c0 + 8'd2);
    end
  endtask
  task automatic test_independence;
    dif.out_ready = 4'b0111;
    send(8'h99, 2'd3);
    dif.in_data = 8'h77;
    dif.in_sel  = 2'd0;
    #1;
    n_cmp++;
    if (dif.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL indep_ready: got in_ready %b expected 1", dif.in_ready);
    end
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    n_cmp++;
    if (dif.out_valid !== 4'b1001 || dat(0) !== 8'h77 || dat(3) !== 8'h99) begin
      n_err++;
      $display("FAIL indep: got valid %b ch0 %h ch3 %h expected 1001 77 99", dif.out_valid, dat(0), dat(3));
    end
    dif.out_ready = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic test_back_to_back;
    logic [7:0] c0, d;
    dif.out_ready = 4'b1111;
    c0 = cnt(2);
    for (int i = 0; i < 16; i++) begin
      d = 8'hC0 + 8'(i);
      dif.in_valid = 1'b1; dif.in_data = d; dif.in_sel = 2'd2;
      #1;
      n_cmp++;
      if (dif.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready beat %0d: got in_ready %b expected 1", i, dif.in_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (dif.out_valid[2] !== 1'b1 || dat(2) !== d) begin
        n_err++;
        $display("FAIL b2b_data beat %0d: got valid %b data %h expected 1 %h", i, dif.out_valid[2], dat(2), d);
      end
    end
    dif.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (cnt(2) !== c0 + 8'd16) begin
      n_err++;
      $display("FAIL b2b_cnt: got %0d expected %0d", cnt(2), c0 + 8'd16);
    end
  endtask
  task automatic test_wrap;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    dif.out_ready = 4'b0001;
    dif.in_valid  = 1'b1;
    dif.in_sel    = 2'd0;
    for (int j = 1; j <= 258; j++) begin
      dif.in_data = 8'(j);
      @(posedge clk); #1;
      if (j == 257) dif.in_valid = 1'b0;
      if (j >= 256) begin
        n_cmp++;
        if (cnt(0) !== 8'(j - 1)) begin
          n_err++;
          $display("FAIL wrap after beat %0d: got %0d expected %0d", j - 1, cnt(0), 8'(j - 1));
        end
      end
    end
  endtask
  initial begin
    test_reset;
    test_routing;
    test_stall;
    test_independence;
    test_back_to_back;
    test_wrap;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
